// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter_if
// Purpose : Requester byte streams plus transmitter start/busy handshake.
// Rev     : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_err;

  // Master is the environment: the requesters and the transmitter.
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, tx_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, tx_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Purpose : Round-robin, burst-locked sharing of one UART transmitter.
// Rev     : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 last_q, last_d;
  logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_err_q, tx_err_d;

  logic                 pick_found;
  logic [OWNER_W-1:0]   pick_idx;
  logic [OWNER_W:0]     cand;
  logic [OWNER_W-1:0]   owner_next;
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;

  // Scan from the highest offset down so the entry nearest ptr wins last.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (OWNER_W + 1)'(i);
      if (cand >= (OWNER_W + 1)'(NUM_REQ)) begin
        cand = cand - (OWNER_W + 1)'(NUM_REQ);
      end
      if (bus.req_valid[cand[OWNER_W-1:0]]) begin
        pick_idx = cand[OWNER_W-1:0];
      end
    end
  end

  assign pick_found = |bus.req_valid;
  assign owner_next = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
  assign sel_valid  = bus.req_valid[owner_q];
  assign sel_last   = bus.req_last[owner_q];
  assign sel_data   = bus.req_data[{owner_q, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    ack_cnt_d   = ack_cnt_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && pick_found) begin
          owner_d     = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        if (sel_valid) begin
          tx_data_d   = sel_data;
          tx_start_d  = 1'b1;
          last_d      = sel_last;
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
          ack_cnt_d   = '0;
          state_d     = ST_WAIT_ACK;
        end else begin
          grant_d = '0;
          ptr_d   = owner_next;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          tx_err_d = 1'b1;
          grant_d  = '0;
          ptr_d    = owner_next;
          state_d  = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          // A last byte that also fills the burst still releases only once.
          if (last_q || (burst_cnt_q == BURST_W'(MAX_BURST))) begin
            grant_d = '0;
            ptr_d   = owner_next;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_START;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      last_q      <= 1'b0;
      ack_cnt_q   <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      ack_cnt_q   <= ack_cnt_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      tx_err_q    <= tx_err_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign bus.req_ready[g] = (state_q == ST_START) && (owner_q == OWNER_W'(g)) && bus.req_valid[g];
  end

  assign bus.grant    = grant_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_err   = tx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Purpose : Directed self-checking bench for uart_tx_arbiter.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .ACK_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises 3 cycles after tx_start and stays high 10 cycles.
  int   tx_cnt  = -1;
  logic tx_dead = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) tx_cnt = -1;
    else if (bus.tx_start && !tx_dead) tx_cnt = 0;
    else if (tx_cnt >= 0) begin
      tx_cnt++;
      if (tx_cnt >= 13) tx_cnt = -1;
    end
    bus.tx_busy = (tx_cnt >= 3);
  end

  logic [3:0] sg_q[$];
  logic [7:0] sd_q[$];
  int         err_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (bus.tx_start) begin
      sg_q.push_back(bus.grant);
      sd_q.push_back(bus.tx_data);
    end
    if (bus.tx_err) err_cnt++;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst           = 1'b1;
    tx_dead       = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sg_q.delete();
    sd_q.delete();
    err_cnt = 0;
  endtask

  task automatic wait_start(input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.grant == 4'b0000) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.req_data  = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    tests_run++;
    if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    tests_run++;
    if (bus.tx_start !== 1'b0 || bus.tx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: start %b err %b want 0 0", bus.tx_start, bus.tx_err); end
    tests_run++;
    if (bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", bus.tx_data); end
    tests_run++;
    if (dut.ptr_q !== 2'd0) begin tests_failed++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q); end
  endtask

  task automatic test_single();
    apply_reset();
    bus.req_data[7:0] = 8'h55;
    bus.req_last      = 4'b0001;
    bus.req_valid     = 4'b0001;
    @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.req_ready !== 4'b0001 || bus.tx_start !== 1'b0) begin
      tests_failed++; $display("FAIL single_c1: grant %b ready %b start %b want 0001 0001 0", bus.grant, bus.req_ready, bus.tx_start);
    end
    @(negedge clk);
    tests_run++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h55 || bus.req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL single_c2: start %b data %h ready %b want 1 55 0000", bus.tx_start, bus.tx_data, bus.req_ready);
    end
    bus.req_valid = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL single_pulse: start %b want 0", bus.tx_start); end
    repeat (12) @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.tx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_c15: grant %b busy %b want 0001 0", bus.grant, bus.tx_busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0000 || dut.ptr_q !== 2'd1) begin
      tests_failed++; $display("FAIL single_release: grant %b ptr %0d want 0000 1", bus.grant, dut.ptr_q);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    bit ok = 1'b0;
    apply_reset();
    bus.req_data  = 32'hA3A2A1A0;
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sg_q.size() >= 5) begin ok = 1'b1; break; end
    end
    bus.req_valid = 4'b0000;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rr_timeout: starts %0d want 5", sg_q.size()); end
    wait_idle(40);
    tests_run++;
    if (sg_q.size() != 5 || bus.grant !== 4'b0000) begin
      tests_failed++; $display("FAIL rr_count: starts %0d grant %b want 5 0000", sg_q.size(), bus.grant);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= sg_q.size() || sg_q[i] !== exp_g[i] || sd_q[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL rr_byte%0d: grant %b data %h want %b %h", i,
                 (i < sg_q.size()) ? sg_q[i] : 4'bx, (i < sd_q.size()) ? sd_q[i] : 8'hxx, exp_g[i], exp_d[i]);
      end
    end
  endtask

  // Requester 2 streams six bytes; the last START finds it invalid and releases without a start.
  task automatic test_burst_limit();
    logic [3:0] exp_g [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0100, 4'b0100};
    logic [7:0] exp_d [7] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h24, 8'h25};
    int n2 = 0;
    bit done3 = 1'b0;
    bit ok = 1'b0;
    apply_reset();
    bus.req_data[23:16] = 8'h20;
    bus.req_data[31:24] = 8'h30;
    bus.req_last        = 4'b1000;
    bus.req_valid       = 4'b1100;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.req_ready[2]) begin
        @(posedge clk); #1;
        n2++;
        if (n2 == 6) bus.req_valid[2] = 1'b0;
        else         bus.req_data[23:16] = 8'h20 + 8'(n2);
      end else if (bus.req_ready[3]) begin
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        done3 = 1'b1;
      end
      if (n2 == 6 && done3) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL burst_timeout: n2 %0d done3 %0d want 6 1", n2, done3); end
    wait_idle(40);
    repeat (3) @(negedge clk);
    tests_run++;
    if (sg_q.size() != 7 || bus.grant !== 4'b0000 || dut.ptr_q !== 2'd3) begin
      tests_failed++; $display("FAIL burst_end: starts %0d grant %b ptr %0d want 7 0000 3", sg_q.size(), bus.grant, dut.ptr_q);
    end
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (i >= sg_q.size() || sg_q[i] !== exp_g[i] || sd_q[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL burst_byte%0d: grant %b data %h want %b %h", i,
                 (i < sg_q.size()) ? sg_q[i] : 4'bx, (i < sd_q.size()) ? sd_q[i] : 8'hxx, exp_g[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_ack_timeout();
    bit seen;
    apply_reset();
    tx_dead       = 1'b1;
    bus.req_data  = 32'h000011_10;
    bus.req_last  = 4'b0011;
    bus.req_valid = 4'b0011;
    wait_start(10, seen);
    tests_run++;
    if (!seen || bus.grant !== 4'b0001) begin tests_failed++; $display("FAIL ack_first_start: seen %0d grant %b want 1 0001", seen, bus.grant); end
    bus.req_valid[0] = 1'b0;
    repeat (15) @(negedge clk);
    tests_run++;
    if (bus.tx_err !== 1'b0 || bus.grant !== 4'b0001) begin
      tests_failed++; $display("FAIL ack_early: err %b grant %b want 0 0001", bus.tx_err, bus.grant);
    end
    @(negedge clk);
    tests_run++;
    if (bus.tx_err !== 1'b1 || bus.grant !== 4'b0000) begin
      tests_failed++; $display("FAIL ack_err: err %b grant %b want 1 0000", bus.tx_err, bus.grant);
    end
    @(negedge clk);
    tests_run++;
    if (bus.tx_err !== 1'b0 || bus.grant !== 4'b0010 || bus.req_ready !== 4'b0010) begin
      tests_failed++; $display("FAIL ack_next: err %b grant %b ready %b want 0 0010 0010", bus.tx_err, bus.grant, bus.req_ready);
    end
    wait_start(5, seen);
    bus.req_valid = 4'b0000;
    wait_idle(30);
    repeat (2) @(negedge clk);
    tests_run++;
    if (!seen || err_cnt != 2 || bus.grant !== 4'b0000) begin
      tests_failed++; $display("FAIL ack_total: seen %0d errs %0d grant %b want 1 2 0000", seen, err_cnt, bus.grant);
    end
    tx_dead = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    bit seen;
    apply_reset();
    bus.req_data  = 32'h43420040;
    bus.req_last  = 4'b1101;
    bus.req_valid = 4'b1100;
    wait_start(10, seen);
    bus.req_valid[2] = 1'b0;
    wait_start(40, seen);
    repeat (5) @(negedge clk);
    tests_run++;
    if (!seen || bus.grant !== 4'b1000 || dut.ptr_q !== 2'd3) begin
      tests_failed++; $display("FAIL rif_setup: seen %0d grant %b ptr %0d want 1 1000 3", seen, bus.grant, dut.ptr_q);
    end
    rst              = 1'b1;
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0 ||
        bus.tx_data !== 8'h00 || bus.tx_err !== 1'b0 || dut.ptr_q !== 2'd0) begin
      tests_failed++;
      $display("FAIL rif_reset: grant %b ready %b start %b data %h err %b ptr %0d want 0000 0000 0 00 0 0",
               bus.grant, bus.req_ready, bus.tx_start, bus.tx_data, bus.tx_err, dut.ptr_q);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL rif_restart: grant %b ready %b want 0001 0001", bus.grant, bus.req_ready);
    end
    @(negedge clk);
    tests_run++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h40 || err_cnt != 0) begin
      tests_failed++; $display("FAIL rif_byte: start %b data %h errs %0d want 1 40 0", bus.tx_start, bus.tx_data, err_cnt);
    end
    bus.req_valid = 4'b0000;
    wait_idle(30);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_ack_timeout();
    test_reset_in_flight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among `NUM_REQ` byte-stream requesters using round-robin arbitration with burst locking. It sits between client logic (command responder, debug/status streams) and the transmitter, and sequences every byte through a start/busy handshake. A grant is held until the owner sends its last byte, reaches `MAX_BURST` bytes, drops its request, or the transmitter fails to acknowledge.

## Interface
- `NUM_REQ`, default 4: number of requesters; minimum 2.
- `MAX_BURST`, default 4: maximum bytes per grant; minimum 1.
- `ACK_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after `tx_start`.
- `clk`, in, 1: the single clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset.
- `req_valid`, in, `NUM_REQ`: per-requester byte available.
- `req_data`, in, 8×`NUM_REQ`: byte for requester i in bits `[8i+7:8i]`.
- `req_last`, in, `NUM_REQ`: the presented byte ends the requester's packet.
- `req_ready`, out, `NUM_REQ`: byte accepted this cycle (combinational, at most one bit set).
- `grant`, out, `NUM_REQ`: one-hot current owner, registered; 0 when idle.
- `tx_start`, out, 1: one-cycle pulse to the transmitter.
- `tx_data`, out, 8: byte for the transmitter; held between starts.
- `tx_busy`, in, 1: transmitter busy, high from shortly after `tx_start` until the frame completes.
- `tx_err`, out, 1: one-cycle pulse when an acknowledge timeout occurs.

## Operation
- Registered state: `state` (IDLE, START, WAIT_ACK, WAIT_DONE), `owner` index, `ptr` (round-robin start index), `burst_cnt` (width clog2(`MAX_BURST`+1)), `last_q`, and `ack_cnt` (width clog2(`ACK_TIMEOUT`+1)).
- **IDLE:** if `tx_busy`==0 and any `req_valid` is set:
  - Pick the first set index scanning `ptr`, `ptr`+1, … modulo `NUM_REQ`.
  - Set `owner` and `grant`, clear `burst_cnt`, go to START.
  - If `tx_busy`==1, stay in IDLE.
- **START:**
  - If `req_valid[owner]`==1, this is the transfer cycle:
    - `req_ready[owner]`=1.
    - Next edge: `tx_data`<=`req_data[owner]`, `tx_start`<=1, `last_q`<=`req_last[owner]`, `burst_cnt`+=1, `ack_cnt`<=0, go to WAIT_ACK.
  - If `req_valid[owner]`==0, release: `grant`<=0, `ptr`<=`owner`+1 mod `NUM_REQ`, go to IDLE.
- **WAIT_ACK:**
  - `tx_busy`==1: go to WAIT_DONE.
  - Otherwise `ack_cnt`+=1.
  - When `ack_cnt` reaches `ACK_TIMEOUT`-1 with `tx_busy` still 0: pulse `tx_err`, release as above, go to IDLE.
- **WAIT_DONE:** when `tx_busy`==0:
  - If `last_q`==1 or `burst_cnt`==`MAX_BURST`: release and go to IDLE.
  - Otherwise go to START with `grant` kept.
- Release always advances `ptr` past the owner. This holds for every release cause, so no requester can starve.
- `req_ready` = (`state`==START) & `req_valid[owner]`, decoded to a one-hot bit. It is never asserted in any other state.
- Unselected requesters must hold their `req_valid` and data stable until accepted; the block never drops a presented byte.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `tx_err`=0, `state`=IDLE, `ptr`=0, `burst_cnt`=0.
- Latency from `req_valid` rising in IDLE (with `tx_busy`=0):
  - `grant` high at cycle +1.
  - `req_ready` high during cycle +1.
  - `tx_start` high during cycle +2, for exactly one cycle.
- Between bursts, a re-arbitration costs one IDLE cycle after release.
- Consecutive bytes in a burst: START follows the `tx_busy` fall by one cycle.
- Simultaneous requests resolve strictly by the `ptr` scan; the same cycle is never split between requesters.
- `req_last` together with `burst_cnt` hitting `MAX_BURST`: a single release, no double advance of `ptr`.
- `rst` asserted in any state: all outputs take reset values at the next edge. An in-flight byte is abandoned with no `tx_err`.
- `NUM_REQ` wrap-around: `ptr` after owner `NUM_REQ`-1 becomes 0.

## Test plan
- Single requester 0 sends 0x55 with `req_last`=1 and a transmitter model (busy 3 cycles after start, 10 cycles high):
  - `req_ready[0]` at cycle 1, `tx_start` at cycle 2 with `tx_data`=0x55.
  - `grant` returns to 0 one cycle after busy falls; `ptr`=1.
- All four requesters valid continuously with `req_last`=1:
  - Grant order is 0,1,2,3,0.
  - Each grant accepts exactly one byte.
- Requester 2 streams six bytes with `req_last`=0 and `MAX_BURST`=4, while requester 3 is valid:
  - Four bytes go out from 2, then grant passes to 3.
  - The remaining two bytes from 2 are sent after 3 releases.
- Transmitter model never raises `tx_busy`:
  - `tx_err` pulses exactly once 16 cycles after `tx_start`.
  - `grant` clears and the next requester is granted.
- Owner drops `req_valid` in START mid-burst: release, with no `tx_start` issued.
- `rst` pulsed during WAIT_DONE: all outputs read reset values on the next cycle, and arbitration restarts at index 0.
